// File: rtl/subtractor_sched_if.sv
// Bundle of the requester, response and subtractor-side signals of subtractor_sched.
// Handshake rule for both req and rsp: a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its payload and valid until that edge.
// The consumer may raise ready whenever it likes.
interface subtractor_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    req_bin;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [DW-1:0]       rsp_diff;
  logic                rsp_bout;

  logic [DW-1:0]       sub_d_a;
  logic [DW-1:0]       sub_d_b;
  logic                sub_bin;
  logic                sub_en_a;
  logic                sub_en_b;
  logic                sub_en_result;
  logic [DW-1:0]       sub_result;
  logic                sub_bout;

  // Environment side: requesters, response consumer and the shared subtractor.
  modport master (
    output req_valid, req_a, req_b, req_bin, rsp_ready, sub_result, sub_bout,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_bout,
    input  sub_d_a, sub_d_b, sub_bin, sub_en_a, sub_en_b, sub_en_result
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_bin, rsp_ready, sub_result, sub_bout,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_bout,
    output sub_d_a, sub_d_b, sub_bin, sub_en_a, sub_en_b, sub_en_result
  );
endinterface

// File: rtl/subtractor_sched.sv
// Round-robin scheduler sharing one registered subtractor among N_REQ requesters.
// One operation walks IDLE -> LOAD -> EXEC -> CAPT -> RESP; the subtractor strobes
// are registered single-cycle pulses, and the response is held until consumed.
module subtractor_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  subtractor_sched_if.slave    bus,
  output logic                 busy,
  output logic [15:0]          op_cnt,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_CAPT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] r_id;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic            r_sub_bin;
  logic            r_sub_en_ab;
  logic            r_sub_en_res;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [DW-1:0]   r_rsp_diff;
  logic            r_rsp_bout;
  logic            r_busy;
  logic [15:0]     r_op_cnt;

  int              w_cand;
  logic            w_gnt_found;
  logic [ID_W-1:0] w_gnt_idx;
  logic [N_REQ-1:0] w_ready;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic            w_sel_bin;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_cand      = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = (int'(r_last_grant) + k) % N_REQ;
      if (!w_gnt_found && bus.req_valid[ID_W'(w_cand)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_W'(w_cand);
      end
    end
  end

  // Grant is only offered in IDLE; reset forces it low even before the first edge.
  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_gnt_found && !rst) begin
      w_ready = N_REQ'(1) << w_gnt_idx;
    end
  end

  assign w_sel_a   = bus.req_a[w_gnt_idx*DW +: DW];
  assign w_sel_b   = bus.req_b[w_gnt_idx*DW +: DW];
  assign w_sel_bin = bus.req_bin[w_gnt_idx];

  // Operation sequencer: latches operands on accept and issues registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sub_bin    <= 1'b0;
      r_sub_en_ab  <= 1'b0;
      r_sub_en_res <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_diff   <= '0;
      r_rsp_bout   <= 1'b0;
      r_busy       <= 1'b0;
      r_op_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_sub_bin    <= w_sel_bin;
            r_id         <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_sub_en_ab  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sub_en_ab  <= 1'b0;
          r_sub_en_res <= 1'b1;
          r_state      <= S_EXEC;
        end
        S_EXEC: begin
          r_sub_en_res <= 1'b0;
          r_sub_bin    <= 1'b0;
          r_state      <= S_CAPT;
        end
        S_CAPT: begin
          r_rsp_diff  <= bus.sub_result;
          r_rsp_bout  <= bus.sub_bout;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_cnt    <= r_op_cnt + 16'd1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_diff      = r_rsp_diff;
  assign bus.rsp_bout      = r_rsp_bout;
  assign bus.sub_d_a       = r_a;
  assign bus.sub_d_b       = r_b;
  assign bus.sub_bin       = r_sub_bin;
  assign bus.sub_en_a      = r_sub_en_ab;
  assign bus.sub_en_b      = r_sub_en_ab;
  assign bus.sub_en_result = r_sub_en_res;
  assign busy              = r_busy;
  assign op_cnt            = r_op_cnt;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_subtractor_sched.sv
// Bench for subtractor_sched: behavioural subtractor, directed scenarios, then a
// randomized phase, all checked against a cycle-phase reference model.
module tb_subtractor_sched;
  localparam int N_REQ = 4;
  localparam int DW    = 16;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + DW + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] op_cnt;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  subtractor_sched_if #(.N_REQ(N_REQ), .DW(DW), .ID_W(ID_W)) bus ();

  subtractor_sched #(.N_REQ(N_REQ), .DW(DW), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .op_cnt      (op_cnt),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared subtractor (rstn = ~rst) ----------------
  logic [DW-1:0] sm_a, sm_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_a           <= '0;
      sm_b           <= '0;
      bus.sub_result <= '0;
      bus.sub_bout   <= 1'b0;
    end else begin
      if (bus.sub_en_a) sm_a <= bus.sub_d_a;
      if (bus.sub_en_b) sm_b <= bus.sub_d_b;
      if (bus.sub_en_result)
        {bus.sub_bout, bus.sub_result} <= {1'b0, sm_a} - {1'b0, sm_b} - {{DW{1'b0}}, bus.sub_bin};
    end
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int m_last  = N_REQ - 1;
  bit m_busy  = 1'b0;
  int m_since = 0;
  bit m_bin   = 1'b0;
  int m_cnt   = 0;

  function automatic int model_grant(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_rsp(input int id, input int a, input int b, input int bin);
    int d;
    d = a - b - bin;
    return {ID_W'(id), DW'(d), (d < 0)};
  endfunction

  // Per-cycle expectations: phase k after the accept cycle decides every strobe.
  always @(negedge clk) begin
    int g;
    logic [N_REQ-1:0] exp_rdy;
    logic [W-1:0] obs;
    if (rst) begin
      exp_q.delete();
      m_last  = N_REQ - 1;
      m_busy  = 1'b0;
      m_since = 0;
      m_cnt   = 0;
    end else begin
      if (m_busy) m_since++;
      g = m_busy ? -1 : model_grant(bus.req_valid, m_last);
      exp_rdy = (g >= 0) ? (N_REQ'(1) << g) : '0;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("busy", busy, m_busy);
      chk("sub_en_a", bus.sub_en_a, m_busy && m_since == 1);
      chk("sub_en_b", bus.sub_en_b, m_busy && m_since == 1);
      chk("sub_en_result", bus.sub_en_result, m_busy && m_since == 2);
      chk("sub_bin", bus.sub_bin, (m_busy && (m_since == 1 || m_since == 2)) ? m_bin : 1'b0);
      chk("rsp_valid", bus.rsp_valid, m_busy && m_since >= 4);
      chk("op_cnt", op_cnt, 32'(m_cnt & 16'hffff));
      obs = {bus.rsp_id, bus.rsp_diff, bus.rsp_bout};
      if (m_busy && m_since >= 4) begin
        chk("rsp_q_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("rsp_data", obs, exp_q[0]);
        if (bus.rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_cnt++;
          m_busy = 1'b0;
        end
      end
      if (g >= 0) begin
        exp_q.push_back(model_rsp(g, int'(bus.req_a[g*DW +: DW]), int'(bus.req_b[g*DW +: DW]),
                                  int'(bus.req_bin[g])));
        m_last  = g;
        m_busy  = 1'b1;
        m_since = 0;
        m_bin   = bus.req_bin[g];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raise a request and return just after the edge that accepts it.
  task automatic do_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin);
    bus.req_valid[id]       = 1'b1;
    bus.req_a[id*DW +: DW]  = a;
    bus.req_b[id*DW +: DW]  = b;
    bus.req_bin[id]         = bin;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_ready[id]) break;
    end
    chk("grant_seen", bus.req_ready[id], 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  // Called right after the accept edge: checks latency and the consumed response.
  task automatic wait_rsp(input logic [W-1:0] exp);
    int lat;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    chk("latency", lat, 4);
    for (int c = 0; c < 60; c++) begin
      if (bus.rsp_valid && bus.rsp_ready) break;
      @(negedge clk);
    end
    chk("rsp_handshake", bus.rsp_valid && bus.rsp_ready, 1'b1);
    chk("rsp_id", bus.rsp_id, exp[W-1 -: ID_W]);
    chk("rsp_diff", bus.rsp_diff, exp[DW:1]);
    chk("rsp_bout", bus.rsp_bout, exp[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_diff"}, bus.rsp_diff, 0);
    chk({tag, "_rsp_bout"}, bus.rsp_bout, 0);
    chk({tag, "_sub_d_a"}, bus.sub_d_a, 0);
    chk({tag, "_sub_d_b"}, bus.sub_d_b, 0);
    chk({tag, "_sub_bin"}, bus.sub_bin, 0);
    chk({tag, "_sub_en_a"}, bus.sub_en_a, 0);
    chk({tag, "_sub_en_b"}, bus.sub_en_b, 0);
    chk({tag, "_sub_en_result"}, bus.sub_en_result, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_cnt"}, op_cnt, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  function automatic logic [DW-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return DW'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int order[$];
    int exp_order[5];
    int hs;
    logic [DW-1:0] a1, b1, a2, b2;
    logic bin1, bin2;
    logic [N_REQ-1:0] seen;

    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_bin   = '0;
    bus.rsp_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic operations, including wrap-around differences and borrow-in.
    do_req(0, 16'd150, 16'd50, 1'b0);
    wait_rsp({2'd0, 16'd100, 1'b0});
    do_req(1, 16'd100, 16'd200, 1'b0);
    wait_rsp({2'd1, 16'd65436, 1'b1});
    do_req(2, 16'd0, 16'd1, 1'b0);
    wait_rsp({2'd2, 16'd65535, 1'b1});
    do_req(3, 16'd300, 16'd200, 1'b1);
    wait_rsp({2'd3, 16'd99, 1'b0});

    // All four requesters contend continuously.
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*DW +: DW] = rnd_operand();
      bus.req_b[i*DW +: DW] = rnd_operand();
      bus.req_bin[i]        = 1'($urandom_range(0, 1));
    end
    bus.req_valid = '1;
    hs = 0;
    for (int c = 0; c < 100 && hs < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) order.push_back(i);
      if (bus.rsp_valid && bus.rsp_ready) hs++;
      if (order.size() == 5 && bus.req_valid != '0) begin
        @(posedge clk);
        #1 bus.req_valid = '0;
      end
    end
    chk("rr_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk("rr_order", order[k], exp_order[k]);
    @(negedge clk);
    chk("rr_op_cnt", op_cnt, 9);
    @(posedge clk);
    #1;

    // Response back-pressure while another requester waits.
    bus.rsp_ready = 1'b0;
    a1 = rnd_operand(); b1 = rnd_operand(); bin1 = 1'($urandom_range(0, 1));
    a2 = rnd_operand(); b2 = rnd_operand(); bin2 = 1'($urandom_range(0, 1));
    do_req(1, a1, b1, bin1);
    bus.req_valid[2]      = 1'b1;
    bus.req_a[2*DW +: DW] = a2;
    bus.req_b[2*DW +: DW] = b2;
    bus.req_bin[2]        = bin2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_data", {bus.rsp_id, bus.rsp_diff, bus.rsp_bout},
          model_rsp(1, int'(a1), int'(b1), int'(bin1)));
      chk("hold_busy", busy, 1'b1);
      chk("hold_no_ready", bus.req_ready, 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", bus.rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    do_req(2, a2, b2, bin2);
    wait_rsp(model_rsp(2, int'(a2), int'(b2), int'(bin2)));

    // Reset in the middle of an operation.
    do_req(2, rnd_operand(), rnd_operand(), 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    a1 = rnd_operand(); b1 = rnd_operand();
    a2 = rnd_operand(); b2 = rnd_operand();
    bus.req_a[0*DW +: DW] = a1; bus.req_b[0*DW +: DW] = b1; bus.req_bin[0] = 1'b0;
    bus.req_a[2*DW +: DW] = a2; bus.req_b[2*DW +: DW] = b2; bus.req_bin[2] = 1'b0;
    bus.req_valid = 4'b0101;
    @(negedge clk);
    chk("post_reset_grant", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    wait_rsp(model_rsp(0, int'(a1), int'(b1), 0));
    do_req(2, a2, b2, 1'b0);
    wait_rsp(model_rsp(2, int'(a2), int'(b2), 0));

    // Randomized traffic with withdrawals and back-pressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      seen = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (seen[i]) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.req_valid[i]      = 1'b1;
            bus.req_a[i*DW +: DW] = rnd_operand();
            bus.req_b[i*DW +: DW] = rnd_operand();
            bus.req_bin[i]        = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 1'b0);
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
